frame_mapper: RTL and testbench

Transmit-side framer: pulls payload bytes from the client (rx axis fifo), builds fixed-size frames (FAS, overhead, payload, CRC-8) and streams them byte-wise to the serial transmitter.
It is the line-side counterpart of the receive demapper; the frame layout and CRC defined here are the ones the demapper checks.
The ARQ request from the receive path is carried to the far end in the overhead byte.

---
 rtl/frame_mapper.sv | 199 +++++++++++++++++++
 tb/tb_frame_mapper.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_mapper.sv
// Transmit-side framer: wraps client payload bytes into fixed-size frames
// (FAS, overhead, sequence, payload, CRC-8) and streams them to the line.
module frame_mapper #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_pyld_data,
  input  logic       i_pyld_data_valid,
  output logic       o_pyld_data_ready,
  output logic [7:0] o_frame_data,
  output logic       o_frame_data_valid,
  output logic       o_frame_data_fas,
  input  logic       i_frame_data_ready,
  input  logic       i_arq_en,
  input  logic       i_arq_en_valid,
  output logic [7:0] o_crc_val,
  output logic [7:0] o_seq_num
);

  localparam logic [7:0]  FAS0          = 8'hF6;
  localparam logic [7:0]  FAS1          = 8'h28;
  localparam logic [1:0]  LAST_ROW      = 2'(ROWS - 1);
  localparam logic [10:0] LAST_COL      = 11'(COLS - 1);
  localparam logic [10:0] LAST_PYLD_COL = 11'(COLS - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PYLD,
    S_CRC,
    S_DONE
  } state_t;

  state_t      state;
  logic [1:0]  hdr_idx;
  logic [1:0]  row;
  logic [10:0] col;
  logic [1:0]  row_nxt;
  logic [10:0] col_nxt;
  logic [7:0]  crc;
  logic [7:0]  crc_nxt;
  logic [7:0]  seq;
  logic [7:0]  crc_val;
  logic        arq_flag;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        fas_q;

  logic        load_ok;
  logic        xfer;
  logic        accept;
  logic        arq_set;
  logic        oh_load;
  logic        last_pyld;

  // Bitwise CRC-8, poly 0x07, MSB first
  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  assign load_ok           = !valid_q || i_frame_data_ready;
  assign xfer              = valid_q && i_frame_data_ready;
  assign o_pyld_data_ready = (state == S_PYLD) && load_ok;
  assign accept            = o_pyld_data_ready && i_pyld_data_valid;
  assign arq_set           = i_arq_en_valid && i_arq_en;
  assign oh_load           = (state == S_HDR) && load_ok && (hdr_idx == 2'd2);
  assign last_pyld         = (row == LAST_ROW) && (col == LAST_PYLD_COL);
  assign crc_nxt           = crc8_upd(crc, i_pyld_data);

  assign o_frame_data       = data_q;
  assign o_frame_data_valid = valid_q;
  assign o_frame_data_fas   = fas_q;
  assign o_crc_val          = crc_val;
  assign o_seq_num          = seq;

  // Row-major position after the byte currently being loaded
  always_comb begin
    col_nxt = col + 11'd1;
    row_nxt = row;
    if (col == LAST_COL) begin
      col_nxt = 11'd0;
      row_nxt = (row == LAST_ROW) ? 2'd0 : row + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      hdr_idx  <= 2'd0;
      row      <= 2'd0;
      col      <= 11'd0;
      crc      <= 8'd0;
      seq      <= 8'd0;
      crc_val  <= 8'd0;
      arq_flag <= 1'b0;
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
      fas_q    <= 1'b0;
    end else begin
      // A set request coinciding with the OH load survives into the next frame
      if (oh_load) begin
        arq_flag <= arq_set;
      end else if (i_arq_en_valid) begin
        arq_flag <= i_arq_en;
      end

      if (xfer) begin
        valid_q <= 1'b0;
        fas_q   <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (i_pyld_data_valid) begin
            state   <= S_HDR;
            hdr_idx <= 2'd0;
          end
        end

        S_HDR: begin
          if (load_ok) begin
            valid_q <= 1'b1;
            fas_q   <= (hdr_idx == 2'd0);
            case (hdr_idx)
              2'd0:    data_q <= FAS0;
              2'd1:    data_q <= FAS1;
              2'd2:    data_q <= {7'd0, arq_flag | arq_set};
              default: data_q <= seq;
            endcase
            if (hdr_idx == 2'd0) begin
              crc <= 8'd0;
            end
            row     <= row_nxt;
            col     <= col_nxt;
            hdr_idx <= hdr_idx + 2'd1;
            if (hdr_idx == 2'd3) begin
              state <= S_PYLD;
            end
          end
        end

        S_PYLD: begin
          if (accept) begin
            data_q  <= i_pyld_data;
            valid_q <= 1'b1;
            fas_q   <= 1'b0;
            crc     <= crc_nxt;
            row     <= row_nxt;
            col     <= col_nxt;
            if (last_pyld) begin
              state <= S_CRC;
            end
          end
        end

        S_CRC: begin
          if (load_ok) begin
            data_q  <= crc;
            valid_q <= 1'b1;
            fas_q   <= 1'b0;
            row     <= row_nxt;
            col     <= col_nxt;
            state   <= S_DONE;
          end
        end

        S_DONE: begin
          // Frame closes when the CRC leaves; next FAS can load in the same cycle
          if (xfer) begin
            seq     <= seq + 8'd1;
            crc_val <= crc;
            if (i_pyld_data_valid) begin
              data_q  <= FAS0;
              valid_q <= 1'b1;
              fas_q   <= 1'b1;
              crc     <= 8'd0;
              row     <= row_nxt;
              col     <= col_nxt;
              hdr_idx <= 2'd1;
              state   <= S_HDR;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_mapper.sv
// Self-checking bench for frame_mapper: a frame-level reference model feeds an
// expected line-byte queue that a monitor compares against every transfer.
module tb_frame_mapper;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 8;
  localparam int unsigned FBYTES = ROWS * COLS;
  localparam int unsigned NPY    = FBYTES - 5;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_pyld_data = 8'd0;
  logic       i_pyld_data_valid = 1'b0;
  logic       o_pyld_data_ready;
  logic [7:0] o_frame_data;
  logic       o_frame_data_valid;
  logic       o_frame_data_fas;
  logic       i_frame_data_ready = 1'b1;
  logic       i_arq_en = 1'b0;
  logic       i_arq_en_valid = 1'b0;
  logic [7:0] o_crc_val;
  logic [7:0] o_seq_num;

  frame_mapper #(.ROWS(ROWS), .COLS(COLS)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_pyld_data        (i_pyld_data),
    .i_pyld_data_valid  (i_pyld_data_valid),
    .o_pyld_data_ready  (o_pyld_data_ready),
    .o_frame_data       (o_frame_data),
    .o_frame_data_valid (o_frame_data_valid),
    .o_frame_data_fas   (o_frame_data_fas),
    .i_frame_data_ready (i_frame_data_ready),
    .i_arq_en           (i_arq_en),
    .i_arq_en_valid     (i_arq_en_valid),
    .o_crc_val          (o_crc_val),
    .o_seq_num          (o_seq_num)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] d;
    logic       f;
    logic       last;
    logic [7:0] crc;
    logic [7:0] seq_after;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] cli_q[$];
  logic [7:0] cap_q[$];
  int         cap_fas_cnt = 0;
  int         total = 0;
  int         bad = 0;
  int         tx_count = 0;
  logic [7:0] m_seq = 8'd0;
  logic       stall_en = 1'b0;
  logic       gap_en = 1'b0;
  logic       acc = 1'b0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_d = 8'd0;
  logic       hold_f = 1'b0;
  logic       chk_pend = 1'b0;
  logic [7:0] chk_crc = 8'd0;
  logic [7:0] chk_seq = 8'd0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, expv, $time);
    end
  endtask

  // CRC as polynomial division of the message bit stream, MSB first
  function automatic logic [7:0] crc8_model(input logic [7:0] b[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'd0;
    foreach (b[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ b[i][k];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic f, input logic last,
                          input logic [7:0] crc, input logic [7:0] sa);
    exp_t e;
    e.d = d; e.f = f; e.last = last; e.crc = crc; e.seq_after = sa;
    exp_q.push_back(e);
  endtask

  task automatic add_frame(input logic [7:0] pl[$], input logic [7:0] oh);
    logic [7:0] c;
    c = crc8_model(pl);
    push_exp(8'hF6, 1'b1, 1'b0, 8'd0, 8'd0);
    push_exp(8'h28, 1'b0, 1'b0, 8'd0, 8'd0);
    push_exp(oh,    1'b0, 1'b0, 8'd0, 8'd0);
    push_exp(m_seq, 1'b0, 1'b0, 8'd0, 8'd0);
    foreach (pl[i]) begin
      push_exp(pl[i], 1'b0, 1'b0, 8'd0, 8'd0);
      cli_q.push_back(pl[i]);
    end
    push_exp(c, 1'b0, 1'b1, c, m_seq + 8'd1);
    m_seq = m_seq + 8'd1;
  endtask

  task automatic add_pattern(input int kind, input int base, input logic [7:0] oh);
    logic [7:0] pl[$];
    for (int i = 0; i < int'(NPY); i++) begin
      case (kind)
        0:       pl.push_back(8'd0);
        1:       pl.push_back(8'(i));
        2:       pl.push_back(8'($urandom));
        default: pl.push_back(8'(base + i));
      endcase
    end
    add_frame(pl, oh);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge i_clk);
      n++;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL %s: %0d line bytes still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
      cli_q.delete();
    end
    repeat (4) @(posedge i_clk);
  endtask

  // Line monitor: compares every transfer, checks hold-while-stalled and frame-end status
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst) begin
      hold_pend = 1'b0;
      chk_pend  = 1'b0;
      acc       = 1'b0;
    end else begin
      if (chk_pend) begin
        check("crc_val", o_crc_val, chk_crc);
        check("seq_num", o_seq_num, chk_seq);
        chk_pend = 1'b0;
      end
      if (hold_pend) begin
        check("hold_valid", 8'(o_frame_data_valid), 8'd1);
        check("hold_data", o_frame_data, hold_d);
        check("hold_fas", 8'(o_frame_data_fas), 8'(hold_f));
      end
      hold_pend = o_frame_data_valid && !i_frame_data_ready;
      hold_d    = o_frame_data;
      hold_f    = o_frame_data_fas;
      acc       = i_pyld_data_valid && o_pyld_data_ready;
      if (o_frame_data_valid && i_frame_data_ready) begin
        tx_count++;
        cap_q.push_back(o_frame_data);
        if (o_frame_data_fas) cap_fas_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %02h expected none", o_frame_data);
        end else begin
          e = exp_q.pop_front();
          check("line_data", o_frame_data, e.d);
          check("line_fas", 8'(o_frame_data_fas), 8'(e.f));
          if (e.last) begin
            chk_pend = 1'b1;
            chk_crc  = e.crc;
            chk_seq  = e.seq_after;
          end
        end
      end
    end
  end

  // Client source: never withdraws a byte that is offered but not yet taken
  always begin
    @(posedge i_clk);
    #2;
    if (acc && cli_q.size() > 0) cli_q.delete(0);
    if (i_rst || cli_q.size() == 0) begin
      i_pyld_data_valid = 1'b0;
      i_pyld_data       = 8'd0;
    end else if (i_pyld_data_valid && !acc) begin
      i_pyld_data = cli_q[0];
    end else if (gap_en && $urandom_range(0, 2) == 0) begin
      i_pyld_data_valid = 1'b0;
    end else begin
      i_pyld_data_valid = 1'b1;
      i_pyld_data       = cli_q[0];
    end
  end

  // Line sink
  always begin
    @(posedge i_clk);
    #2;
    i_frame_data_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  o_frame_data, 8'd0);
    check({tag, "_valid"}, 8'(o_frame_data_valid), 8'd0);
    check({tag, "_fas"},   8'(o_frame_data_fas), 8'd0);
    check({tag, "_ready"}, 8'(o_pyld_data_ready), 8'd0);
    check({tag, "_crc"},   o_crc_val, 8'd0);
    check({tag, "_seq"},   o_seq_num, 8'd0);
  endtask

  initial begin
    int base;
    int n;
    logic [7:0] pl[$];

    // Model pins: CRC-8/0x07 check value and a single-byte case
    pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("model_crc_check", crc8_model(pl), 8'hF4);
    pl = '{8'h80};
    check("model_crc_80", crc8_model(pl), 8'h89);

    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs("rst0");
    i_rst = 1'b0;

    // All-zero payload frame
    cap_q.delete();
    cap_fas_cnt = 0;
    add_pattern(0, 0, 8'h00);
    wait_drain("zero_frame", 400);
    check("z_fas0", cap_q[0], 8'hF6);
    check("z_fas1", cap_q[1], 8'h28);
    check("z_oh", cap_q[2], 8'h00);
    check("z_seq", cap_q[3], 8'h00);
    check("z_crc", cap_q[31], 8'h00);
    check("z_fas_count", 8'(cap_fas_cnt), 8'd1);
    check("z_seq_num", o_seq_num, 8'd1);
    check("z_crc_val", o_crc_val, 8'h00);

    // Counting payload, two frames back to back
    cap_q.delete();
    add_pattern(1, 0, 8'h00);
    add_pattern(1, 0, 8'h00);
    wait_drain("count_frames", 400);
    check("c_first_pyld", cap_q[4], 8'h00);
    check("c_last_pyld", cap_q[30], 8'h1A);
    check("c_seq_f1", cap_q[3], 8'h01);
    check("c_seq_f2", cap_q[35], 8'h02);

    // Random line backpressure and client gaps
    stall_en = 1'b1;
    gap_en   = 1'b1;
    add_pattern(2, 0, 8'h00);
    add_pattern(1, 0, 8'h00);
    add_pattern(2, 0, 8'h00);
    wait_drain("stall_frames", 3000);
    stall_en = 1'b0;
    gap_en   = 1'b0;
    repeat (3) @(posedge i_clk);

    // ARQ pulse mid-payload: next frame carries 1, the one after 0
    cap_q.delete();
    base = tx_count;
    add_pattern(3, 5, 8'h00);
    add_pattern(3, 6, 8'h01);
    add_pattern(3, 7, 8'h00);
    n = 0;
    while ((tx_count - base) < 15 && n < 300) begin
      @(posedge i_clk);
      n++;
    end
    check("arq_mid_reached", 8'((tx_count - base) >= 15), 8'd1);
    @(posedge i_clk);
    #1;
    i_arq_en = 1'b1; i_arq_en_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_arq_en = 1'b0; i_arq_en_valid = 1'b0;
    wait_drain("arq_mid", 500);
    check("arq_mid_oh0", cap_q[2], 8'h00);
    check("arq_mid_oh1", cap_q[34], 8'h01);
    check("arq_mid_oh2", cap_q[66], 8'h00);

    // ARQ pulse coincident with the OH load: two frames carry 1
    cap_q.delete();
    add_pattern(3, 9, 8'h01);
    add_pattern(3, 10, 8'h01);
    add_pattern(3, 11, 8'h00);
    n = 0;
    @(posedge i_clk);
    #1;
    while (!o_frame_data_fas && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("arq_co_fas_seen", 8'(o_frame_data_fas), 8'd1);
    @(posedge i_clk);
    #1;
    i_arq_en = 1'b1; i_arq_en_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_arq_en = 1'b0; i_arq_en_valid = 1'b0;
    wait_drain("arq_co", 500);
    check("arq_co_oh0", cap_q[2], 8'h01);
    check("arq_co_oh1", cap_q[34], 8'h01);
    check("arq_co_oh2", cap_q[66], 8'h00);

    // Reset at payload byte 10 of the second frame
    base = tx_count;
    add_pattern(3, 20, 8'h00);
    add_pattern(3, 21, 8'h00);
    n = 0;
    while ((tx_count - base) < 46 && n < 400) begin
      @(posedge i_clk);
      n++;
    end
    check("rst_point_reached", 8'((tx_count - base) >= 46), 8'd1);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    exp_q.delete();
    cli_q.delete();
    @(posedge i_clk);
    #1;
    check_reset_outputs("rst_mid");
    i_rst = 1'b0;
    m_seq = 8'd0;
    cap_q.delete();
    add_pattern(3, 40, 8'h00);
    wait_drain("after_reset", 400);
    check("ar_fas0", cap_q[0], 8'hF6);
    check("ar_seq", cap_q[3], 8'h00);

    // 257 frames: sequence field wraps through FF to 00
    cap_q.delete();
    for (int f = 0; f < 257; f++) add_pattern(3, f, 8'h00);
    wait_drain("seq_wrap", 20000);
    check("wrap_seq_ff", cap_q[254 * FBYTES + 3], 8'hFF);
    check("wrap_seq_00", cap_q[255 * FBYTES + 3], 8'h00);
    check("wrap_seq_num", o_seq_num, 8'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
